// File: rtl/ins_cache_r32i_if.sv
// Refill bus between the instruction cache (master) and instruction memory (slave).
interface ins_cache_r32i_if #(
    parameter int unsigned dataW = 32
);
    logic             MemReq;
    logic [dataW-1:0] MemAddr;
    logic             MemValid;
    logic [dataW-1:0] MemData;

    modport master (output MemReq, output MemAddr, input MemValid, input MemData);
    modport slave  (input MemReq, input MemAddr, output MemValid, output MemData);
endinterface

// File: rtl/ins_cache_r32i.sv
// Direct-mapped read-only instruction cache with a one-beat-per-cycle line refill.
// Optional feature: define ICACHE_FLUSH_EN to add the Flush port (invalidate all lines).
module ins_cache_r32i #(
    parameter int unsigned dataW = 32,
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [dataW-1:0] ProgAddr,
    output logic [dataW-1:0] Instruction,
    output logic             InsCacheStall,
    output logic             InsMisaligned,
`ifdef ICACHE_FLUSH_EN
    input  logic             Flush,
`endif
    ins_cache_r32i_if.master mem
);
    localparam int unsigned wordBits = $clog2(WORDS);
    localparam int unsigned idxBits  = $clog2(LINES);
    localparam int unsigned offBits  = wordBits + 2;
    localparam int unsigned tagBits  = dataW - offBits - idxBits;
    localparam logic [dataW-1:0] NOP = dataW'(32'h0000_0013);

    typedef enum logic {IDLE, REFILL} state_t;

    state_t               state, stateNext;
    logic                 startRefill;
    logic [LINES-1:0]     validBits;
    logic [tagBits-1:0]   tagMem  [LINES];
    logic [dataW-1:0]     dataMem [LINES][WORDS];
    logic [dataW-1:0]     baseAddr;
    logic [wordBits-1:0]  beat;
    logic                 flushReq;
    logic                 flushPend;
    logic                 hit;
    logic                 lastBeat;

    logic [idxBits-1:0]   lkIdx;
    logic [tagBits-1:0]   lkTag;
    logic [wordBits-1:0]  lkWord;
    logic [idxBits-1:0]   rfIdx;
    logic [tagBits-1:0]   rfTag;

`ifdef ICACHE_FLUSH_EN
    assign flushReq = Flush;
`else
    assign flushReq = 1'b0;
`endif

    assign lkIdx  = ProgAddr[offBits +: idxBits];
    assign lkTag  = ProgAddr[dataW-1 -: tagBits];
    assign lkWord = ProgAddr[2 +: wordBits];
    assign rfIdx  = baseAddr[offBits +: idxBits];
    assign rfTag  = baseAddr[dataW-1 -: tagBits];

    // Lookup only answers while idle; a flush request forces a stall that cycle.
    assign hit      = (state == IDLE) && validBits[lkIdx] && (tagMem[lkIdx] == lkTag) && !flushReq;
    assign lastBeat = (state == REFILL) && mem.MemValid && (beat == wordBits'(WORDS - 1));

    assign Instruction   = hit ? dataMem[lkIdx][lkWord] : NOP;
    assign InsCacheStall = !hit;
    assign InsMisaligned = |ProgAddr[1:0];
    assign mem.MemReq    = (state == REFILL);
    assign mem.MemAddr   = (state == REFILL) ? baseAddr + dataW'({beat, 2'b00}) : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext   = state;
        startRefill = 1'b0;
        case (state)
            IDLE: begin
                if (!hit && !flushReq) begin
                    stateNext   = REFILL;
                    startRefill = 1'b1;
                end
            end
            REFILL: begin
                if (lastBeat) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Refill bookkeeping and valid bits; a flush seen mid-refill is deferred to the end of the line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            validBits <= '0;
            beat      <= '0;
            baseAddr  <= '0;
            flushPend <= 1'b0;
        end else begin
            if (startRefill) begin
                baseAddr <= {ProgAddr[dataW-1:offBits], offBits'(0)};
                beat     <= '0;
            end else if (state == REFILL && mem.MemValid) begin
                beat <= beat + wordBits'(1);
            end

            if (state == IDLE && flushReq) begin
                validBits <= '0;
            end else if (lastBeat) begin
                if (flushPend || flushReq) validBits <= '0;
                else                       validBits[rfIdx] <= 1'b1;
                flushPend <= 1'b0;
            end else if (state == REFILL && flushReq) begin
                flushPend <= 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clock) begin
        if (state == REFILL && mem.MemValid) begin
            dataMem[rfIdx][beat] <= mem.MemData;
            if (lastBeat) tagMem[rfIdx] <= rfTag;
        end
    end
endmodule

// File: tb/tb_ins_cache_r32i.sv
// Self-checking bench for ins_cache_r32i: directed scenarios plus randomized fetch/refill traffic.
module tb_ins_cache_r32i;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ProgAddr = 32'h0;
    logic [31:0] Instruction;
    logic        InsCacheStall;
    logic        InsMisaligned;
    logic        Flush = 1'b0;

    int total = 0;
    int bad   = 0;

    ins_cache_r32i_if #(.dataW(32)) memBus ();

    ins_cache_r32i dut (
        .clock        (clock),
        .reset        (reset),
        .ProgAddr     (ProgAddr),
        .Instruction  (Instruction),
        .InsCacheStall(InsCacheStall),
        .InsMisaligned(InsMisaligned),
`ifdef ICACHE_FLUSH_EN
        .Flush        (Flush),
`endif
        .mem          (memBus)
    );

    always #5 clock = ~clock;

    // Instruction memory contents: a fixed function of the word address.
    function automatic logic [31:0] memFunc(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    assign memBus.MemData = memFunc(memBus.MemAddr);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: which lines hold which tag, and progress of the outstanding refill.
    bit          mValid [16];
    logic [23:0] mTag   [16];
    bit          mBusy     = 1'b0;
    bit          mPend     = 1'b0;
    logic [31:0] mBase     = 32'h0;
    int          mBeats    = 0;

    function automatic bit mHit(input logic [31:0] a);
        return !mBusy && !Flush && mValid[a[7:4]] && (mTag[a[7:4]] == a[31:8]);
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            foreach (mValid[i]) mValid[i] = 1'b0;
            mBusy = 1'b0; mPend = 1'b0; mBeats = 0;
        end else if (mBusy) begin
            if (Flush) mPend = 1'b1;
            if (memBus.MemValid) begin
                mBeats++;
                if (mBeats == 4) begin
                    mBusy = 1'b0;
                    if (mPend) foreach (mValid[i]) mValid[i] = 1'b0;
                    else begin
                        mValid[mBase[7:4]] = 1'b1;
                        mTag[mBase[7:4]]   = mBase[31:8];
                    end
                    mPend = 1'b0;
                end
            end
        end else if (Flush) begin
            foreach (mValid[i]) mValid[i] = 1'b0;
        end else if (!mHit(ProgAddr)) begin
            mBusy  = 1'b1;
            mBase  = {ProgAddr[31:4], 4'h0};
            mBeats = 0;
        end
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge clock) begin
        bit eHit;
        eHit = mHit(ProgAddr);
        check("m_stall", 32'(InsCacheStall), 32'(!eHit));
        check("m_instr", Instruction, eHit ? memFunc({ProgAddr[31:2], 2'b00}) : NOP);
        check("m_misaligned", 32'(InsMisaligned), 32'(|ProgAddr[1:0]));
        check("m_memreq", 32'(memBus.MemReq), 32'(mBusy));
        if (mBusy) check("m_memaddr", memBus.MemAddr, mBase + 32'(4 * mBeats));
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic missCycle(input logic [31:0] a);
        ProgAddr = a;
        @(negedge clock);
        check("miss_stall", 32'(InsCacheStall), 32'd1);
        check("miss_instr", Instruction, NOP);
        check("miss_req", 32'(memBus.MemReq), 32'd0);
        tick();
    endtask

    task automatic doRefill(input logic [31:0] base, input int holdBeat, input int holdCycles);
        for (int b = 0; b < 4; b++) begin
            if (b == holdBeat) begin
                memBus.MemValid = 1'b0;
                for (int h = 0; h < holdCycles; h++) begin
                    @(negedge clock);
                    check("hold_req", 32'(memBus.MemReq), 32'd1);
                    check("hold_addr", memBus.MemAddr, base + 32'(4 * b));
                    check("hold_stall", 32'(InsCacheStall), 32'd1);
                    tick();
                end
            end
            memBus.MemValid = 1'b1;
            @(negedge clock);
            check("beat_req", 32'(memBus.MemReq), 32'd1);
            check("beat_addr", memBus.MemAddr, base + 32'(4 * b));
            check("beat_stall", 32'(InsCacheStall), 32'd1);
            tick();
        end
        memBus.MemValid = 1'b0;
    endtask

    task automatic hitCycle(input logic [31:0] a, input logic [31:0] expData);
        ProgAddr = a;
        @(negedge clock);
        check("hit_stall", 32'(InsCacheStall), 32'd0);
        check("hit_instr", Instruction, expData);
        check("hit_req", 32'(memBus.MemReq), 32'd0);
        tick();
    endtask

    initial begin
        memBus.MemValid = 1'b0;
        ProgAddr = 32'h10;
        repeat (2) tick();
        @(negedge clock);
        check("rst_stall", 32'(InsCacheStall), 32'd1);
        check("rst_instr", Instruction, NOP);
        check("rst_req", 32'(memBus.MemReq), 32'd0);
        check("rst_addr", memBus.MemAddr, 32'h0);
        tick();
        reset = 1'b0;

        // Cold miss and refill, then the rest of the line hits.
        missCycle(32'h10);
        doRefill(32'h10, -1, 0);
        hitCycle(32'h10, 32'hFFEF_0010);
        hitCycle(32'h14, 32'hFFEB_0014);
        hitCycle(32'h18, 32'hFFE7_0018);
        hitCycle(32'h1C, 32'hFFE3_001C);

        // Conflict eviction on index 1.
        missCycle(32'h110);
        doRefill(32'h110, -1, 0);
        hitCycle(32'h110, 32'hFEEF_0110);
        hitCycle(32'h11C, 32'hFEE3_011C);
        missCycle(32'h10);

        // Memory stalls beat 2 for three cycles.
        doRefill(32'h10, 2, 3);
        hitCycle(32'h18, 32'hFFE7_0018);

        ProgAddr = 32'h12;
        @(negedge clock);
        check("misal_flag", 32'(InsMisaligned), 32'd1);
        check("misal_instr", Instruction, 32'hFFEF_0010);
        check("misal_stall", 32'(InsCacheStall), 32'd0);
        tick();

        // Reset in the middle of a refill.
        missCycle(32'h210);
        memBus.MemValid = 1'b1;
        repeat (2) begin
            @(negedge clock);
            tick();
        end
        reset = 1'b1;
        #1;
        check("rst_mid_req", 32'(memBus.MemReq), 32'd0);
        check("rst_mid_addr", memBus.MemAddr, 32'h0);
        check("rst_mid_stall", 32'(InsCacheStall), 32'd1);
        check("rst_mid_instr", Instruction, NOP);
        memBus.MemValid = 1'b0;
        tick();
        reset = 1'b0;
        missCycle(32'h10);
        doRefill(32'h10, -1, 0);
        hitCycle(32'h10, 32'hFFEF_0010);

`ifdef ICACHE_FLUSH_EN
        Flush = 1'b1;
        ProgAddr = 32'h10;
        @(negedge clock);
        check("flush_idle_stall", 32'(InsCacheStall), 32'd1);
        check("flush_idle_req", 32'(memBus.MemReq), 32'd0);
        tick();
        Flush = 1'b0;
        missCycle(32'h10);
        Flush = 1'b1;
        doRefill(32'h10, -1, 0);
        Flush = 1'b0;
        missCycle(32'h10);
        doRefill(32'h10, -1, 0);
        hitCycle(32'h14, 32'hFFEB_0014);
`endif

        // Randomized traffic; the PC mostly holds its address while stalled.
        for (int c = 0; c < 3000; c++) begin
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 199) == 0) reset = 1'b1;
            if (mHit(ProgAddr) || $urandom_range(0, 99) < 15) begin
                logic [23:0] t;
                case ($urandom_range(0, 3))
                    0: t = 24'h0;
                    1: t = 24'h1;
                    2: t = 24'h2;
                    default: t = 24'hABCDE;
                endcase
                ProgAddr = {t,
                            4'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 15 : 3)),
                            2'($urandom_range(0, 3)),
                            ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
            end
            memBus.MemValid = ($urandom_range(0, 9) < 6);
`ifdef ICACHE_FLUSH_EN
            Flush = ($urandom_range(0, 39) == 0);
`endif
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
